button_debounce: RTL
====================

# button_debounce

Input-side counterpart to the blinker: conditions a raw, bouncing pushbutton or switch input into a clean debounced level and one-cycle press/release pulses. It sits between a board pin and user logic, alongside the LED blinker. It shares the same FREQ-based timing parameterisation, so debounce time is set in milliseconds rather than cycles. A wrapping press counter is included for board bring-up and self-test.

## Interface
- FREQ, 0: clock frequency in Hz.
- MSECS, 0: debounce time in milliseconds. N = FREQ*MSECS/1000 is the number of stable cycles required. If N == 0, elaboration fails with `$error`.
- CNT_W, 8: width of the press counter.

- clk_i  in  1  single clock; all logic on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- sw_i  in  1  raw asynchronous button/switch input, active-high.
- btn_o  out  1  debounced level.
- press_o  out  1  one-cycle pulse on debounced 0->1.
- release_o  out  1  one-cycle pulse on debounced 1->0.
- presses_o  out  CNT_W  count of debounced presses, wraps modulo 2^CNT_W.

## Operation
- sw_i passes through a 2-flop synchroniser (s1, s2). Only s2 (call it s) feeds the FSM.
- Stability counter cnt is wide enough for N-1 (clog2(N), minimum 1 bit).
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
  - LOW: btn_o=0. If s==1, go to WAIT_HIGH and set cnt=0.
  - WAIT_HIGH: btn_o=0.
    - s==0: return to LOW (bounce rejected). No pulse.
    - s==1 and cnt==N-1: go to HIGH; press_o=1 for that one cycle; presses_o increments.
    - Otherwise: cnt increments.
  - HIGH: btn_o=1. If s==0, go to WAIT_LOW and set cnt=0.
  - WAIT_LOW: mirror of WAIT_HIGH. s==1 returns to HIGH. Reaching N-1 with s==0 goes to LOW with release_o=1 for one cycle.
- btn_o, press_o, release_o and presses_o are registered outputs.
- press_o and release_o are never high in the same cycle and never high for two consecutive cycles.
- presses_o wraps from 2^CNT_W-1 to 0 with no flag. Releases are not counted.
- A bounce of any length shorter than N stable cycles never changes btn_o.

## Timing
- Reset (rst_ni low at a rising edge) gives: s1=s2=0, state LOW, cnt=0, btn_o=0, press_o=0, release_o=0, presses_o=0.
- Reset overrides everything. Asserting it in WAIT_* or HIGH returns to LOW on that edge with no release_o pulse.
- After rst_ni deasserts, a button already held high is treated as a fresh press. press_o fires per the latency rule below.
- Latency: let sw_i go high and stay high before edge E0.
  - E0: s1=1.
  - E0+1: s2=1.
  - E0+2: WAIT_HIGH, cnt=0.
  - E0+N+2: HIGH; btn_o=1 and press_o=1 visible after this edge.
  - Total: N+3 edges including the sampling edge. Release is symmetric.
- N==1 is legal. The transition occurs on the edge after entering WAIT_*.
- A glitch on s at the exact cycle cnt==N-1 (s opposite to target) aborts the transition with no pulse.

## Test plan
- Reset check (FREQ=1000, MSECS=4, N=4): hold rst_ni=0 for 3 cycles with sw_i=1 -> all outputs 0. Release reset -> btn_o=1 and press_o=1 exactly 7 edges (N+3) after the first edge sampling rst_ni=1. presses_o=1.
- Clean press/release (N=4): sw_i high for 20 cycles, then low.
  - btn_o rises N+3 edges after sw_i.
  - release_o pulses once, N+3 edges after the fall.
  - press_o fires exactly once; presses_o=1.
- Bounce rejection (N=4): sw_i pattern 1,0,1,1,0,1,1,1,0 (each level held 1 cycle) from LOW -> btn_o stays 0, no pulses. Then sw_i held high -> a single press_o.
- Boundary abort (N=4): sw_i high for exactly 3 synchronised cycles, then low -> no press_o, state returns to LOW. Next press is clean and presses_o=1.
- Counter wrap (CNT_W=2, N=1): 5 clean presses -> presses_o sequence 1,2,3,0,1. press_o count=5, release_o count=5.
- Reset mid-operation: assert rst_ni=0 while in HIGH -> btn_o=0 on that edge, no release_o, presses_o=0.

Source files
------------

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability-counting FSM,
// registered debounced level, press/release pulses and a wrapping press counter.
module button_debounce #(
    parameter int FREQ  = 0,
    parameter int MSECS = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sw_i,
    output logic             btn_o,
    output logic             press_o,
    output logic             release_o,
    output logic [CNT_W-1:0] presses_o
);

    // Product taken in 64 bits so large FREQ*MSECS cannot overflow.
    localparam longint N  = longint'(FREQ) * longint'(MSECS) / 64'sd1000;
    localparam int     CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (N == 0) begin : g_bad_n
            $error("button_debounce: FREQ*MSECS/1000 must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

    state_t        state;
    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            state     <= LOW;
            cnt       <= '0;
            btn_o     <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            presses_o <= '0;
        end else begin
            s1        <= sw_i;
            s2        <= s1;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            case (state)
                LOW: begin
                    if (s2) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    // Any low sample, even on the final count, rejects the edge.
                    if (!s2) begin
                        state <= LOW;
                    end else if (cnt == LAST) begin
                        state     <= HIGH;
                        btn_o     <= 1'b1;
                        press_o   <= 1'b1;
                        presses_o <= presses_o + CNT_W'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s2) begin
                        state <= HIGH;
                    end else if (cnt == LAST) begin
                        state     <= LOW;
                        btn_o     <= 1'b0;
                        release_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= LOW;
            endcase
        end
    end

endmodule
